usb_crc_serial: RTL and testbench

//  Parametrised serial CRC engine for the USB bit path; one instance per CRC flavour (CRC5 tokens, CRC16 data).

---
 rtl/usb_crc_serial.sv | 120 ++++++++++++
 tb/tb_usb_crc_serial.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_crc_serial.sv
// Serial USB CRC engine: generate mode passes data through then appends the inverted CRC MSB first;
// check mode runs the whole field, CRC included, and compares the register against the residual.
//
// state | meaning
// IDLE  | waiting for stream_begin; out follows in
// SHIFT | stepping the register once per data bit
// SEND  | emitting inverted CRC bits, count 0..CRC_W-1
module usb_crc_serial #(
  parameter int                 CRC_W    = 5,
  parameter logic [CRC_W-1:0]   POLY     = 5'b00101,
  parameter logic [CRC_W-1:0]   INIT     = 5'b11111,
  parameter logic [CRC_W-1:0]   RESIDUAL = 5'b01100
) (
  input  logic clk,
  input  logic rst_L,
  input  logic in,
  input  logic stream_begin,
  input  logic stream_done,
  input  logic mode_check,
  input  logic halt_stream,
  output logic out,
  output logic crc_busy,
  output logic crc_done,
  output logic crc_ok,
  output logic crc_err
);

  localparam int CW = (CRC_W > 1) ? $clog2(CRC_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(CRC_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, SEND} state_t;

  state_t             state, state_n;
  logic [CRC_W-1:0]   crc, crc_n;
  logic [CW-1:0]      count, count_n;
  logic               mode, mode_n;
  logic               done_n, ok_n, err_n;
  logic [CRC_W-1:0]   crc_sh;
  logic               start;
  logic               eff_mode;
  logic [CRC_W-1:0]   step_base;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state    <= IDLE;
      crc      <= INIT;
      count    <= '0;
      mode     <= 1'b0;
      crc_done <= 1'b0;
      crc_ok   <= 1'b0;
      crc_err  <= 1'b0;
    end else begin
      state    <= state_n;
      crc      <= crc_n;
      count    <= count_n;
      mode     <= mode_n;
      crc_done <= done_n;
      crc_ok   <= ok_n;
      crc_err  <= err_n;
    end
  end

  // A begin in IDLE or SHIFT restarts from INIT, never from the stale register.
  assign start     = stream_begin && (state != SEND);
  assign eff_mode  = start ? mode_check : mode;
  assign step_base = start ? INIT : crc;

  always_comb begin
    state_n = state;
    crc_n   = crc;
    count_n = count;
    mode_n  = mode;
    done_n  = 1'b0;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    if (!halt_stream) begin
      case (state)
        IDLE, SHIFT: begin
          if (start || state == SHIFT) begin
            crc_n   = crc_step(step_base, in);
            mode_n  = eff_mode;
            state_n = SHIFT;
            if (stream_done) begin
              if (eff_mode) begin
                state_n = IDLE;
                done_n  = 1'b1;
                ok_n    = (crc_n == RESIDUAL);
                err_n   = (crc_n != RESIDUAL);
              end else begin
                state_n = SEND;
                count_n = '0;
              end
            end
          end
        end
        SEND: begin
          if (count == LAST) begin
            state_n = IDLE;
            count_n = '0;
            done_n  = 1'b1;
          end else begin
            count_n = count + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign crc_sh   = crc << count;
  assign out      = (state == SEND) ? ~crc_sh[CRC_W-1] : in;
  assign crc_busy = (state != IDLE);

endmodule

// File: tb/tb_usb_crc_serial.sv
// Scoreboard bench for usb_crc_serial: a CRC5 and a CRC16 instance, expectations queued per cycle
// from a bench model and compared as the DUT produces them.
module tb_usb_crc_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_L, in_s, beg, dn, mode, halt, sel16;
  logic out5, busy5, done5, ok5, err5;
  logic out16, busy16, done16, ok16, err16;
  logic out_o, busy_o, done_o, ok_o, err_o;

  int compared = 0;
  int mismatched = 0;

  typedef struct { bit i; bit b; bit d; bit h; } stim_t;
  typedef struct { bit o; bit busy; bit done; bit ok; bit err; } exp_t;
  stim_t stim_q[$];
  exp_t  exp_q[$];

  usb_crc_serial #(.CRC_W(5), .POLY(5'b00101), .INIT(5'b11111), .RESIDUAL(5'b01100)) dut5 (
    .clk(clk), .rst_L(rst_L), .in(in_s & ~sel16), .stream_begin(beg & ~sel16),
    .stream_done(dn & ~sel16), .mode_check(mode), .halt_stream(halt & ~sel16),
    .out(out5), .crc_busy(busy5), .crc_done(done5), .crc_ok(ok5), .crc_err(err5));

  usb_crc_serial #(.CRC_W(16), .POLY(16'h8005), .INIT(16'hFFFF), .RESIDUAL(16'h800D)) dut16 (
    .clk(clk), .rst_L(rst_L), .in(in_s & sel16), .stream_begin(beg & sel16),
    .stream_done(dn & sel16), .mode_check(mode), .halt_stream(halt & sel16),
    .out(out16), .crc_busy(busy16), .crc_done(done16), .crc_ok(ok16), .crc_err(err16));

  assign out_o  = sel16 ? out16  : out5;
  assign busy_o = sel16 ? busy16 : busy5;
  assign done_o = sel16 ? done16 : done5;
  assign ok_o   = sel16 ? ok16   : ok5;
  assign err_o  = sel16 ? err16  : err5;

  function automatic logic [15:0] model_crc(input bit is16, input bit bits[$]);
    logic [15:0] c, poly, mask;
    bit fb;
    int w;
    w    = is16 ? 16 : 5;
    c    = is16 ? 16'hFFFF : 16'h001F;
    poly = is16 ? 16'h8005 : 16'h0005;
    mask = is16 ? 16'hFFFF : 16'h001F;
    foreach (bits[k]) begin
      fb = c[w-1] ^ bits[k];
      c  = (c << 1) & mask;
      if (fb) c = c ^ poly;
    end
    return c;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 4 ns later, before the next rising edge.
  task automatic tick(input bit i, input bit b, input bit d, input bit h);
    @(negedge clk);
    in_s = i; beg = b; dn = d; halt = h;
    #4;
  endtask

  task automatic run_field(input bit is16, input bit chk, input bit bits[$], input int halt_at,
                           input int halt_len, input bit first_busy, output logic [15:0] sent,
                           output int sent_n);
    logic [15:0] c, res;
    int w, n, cyc;
    bit ok, sbit;
    stim_t s;
    exp_t e;
    w = is16 ? 16 : 5;
    n = bits.size();
    res = is16 ? 16'h800D : 16'h000C;
    sel16 = is16; mode = chk;
    c  = model_crc(is16, bits);
    ok = (c == res);
    stim_q.delete(); exp_q.delete();
    for (int k = 0; k < n; k++) begin
      stim_q.push_back('{bits[k], k == 0, k == n - 1, 1'b0});
      exp_q.push_back('{bits[k], (k == 0) ? first_busy : 1'b1, 1'b0, 1'b0, 1'b0});
    end
    if (!chk) begin
      for (int j = 0; j < w; j++) begin
        sbit = ~c[w-1-j];
        if (j == halt_at)
          for (int r = 0; r < halt_len; r++) begin
            stim_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
            exp_q.push_back('{sbit, 1'b1, 1'b0, 1'b0, 1'b0});
          end
        stim_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{sbit, 1'b1, 1'b0, 1'b0, 1'b0});
      end
    end
    stim_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
    exp_q.push_back('{1'b0, 1'b0, 1'b1, chk && ok, chk && !ok});
    sent = '0; sent_n = 0; cyc = 0;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      tick(s.i, s.b, s.d, s.h);
      e = exp_q.pop_front();
      compared += 5;
      if (out_o !== e.o) begin mismatched++; $display("FAIL out cyc=%0d got=%b exp=%b", cyc, out_o, e.o); end
      if (busy_o !== e.busy) begin mismatched++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, e.busy); end
      if (done_o !== e.done) begin mismatched++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done_o, e.done); end
      if (ok_o !== e.ok) begin mismatched++; $display("FAIL ok cyc=%0d got=%b exp=%b", cyc, ok_o, e.ok); end
      if (err_o !== e.err) begin mismatched++; $display("FAIL err cyc=%0d got=%b exp=%b", cyc, err_o, e.err); end
      if (!chk && cyc >= n && stim_q.size() > 0 && !s.h) begin
        sent = {sent[14:0], out_o};
        sent_n++;
      end
      cyc++;
    end
  endtask

  function automatic void zeros(output bit q[$], input int n);
    q.delete();
    for (int k = 0; k < n; k++) q.push_back(1'b0);
  endfunction

  task automatic test_reset();
    rst_L = 1'b0; sel16 = 1'b0; mode = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    compared += 5;
    if (busy_o !== 1'b0) begin mismatched++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    if (done_o !== 1'b0) begin mismatched++; $display("FAIL rst_done got=%b exp=0", done_o); end
    if (ok_o !== 1'b0 || err_o !== 1'b0) begin mismatched++; $display("FAIL rst_okerr got=%b%b exp=00", ok_o, err_o); end
    if (out_o !== 1'b1) begin mismatched++; $display("FAIL rst_pass got=%b exp=1", out_o); end
    if (busy16 !== 1'b0) begin mismatched++; $display("FAIL rst_busy16 got=%b exp=0", busy16); end
    @(negedge clk);
    rst_L = 1'b1; in_s = 1'b0;
  endtask

  task automatic test_crc5_gen();
    bit q[$]; logic [15:0] sent; int sn;
    zeros(q, 11);
    run_field(1'b0, 1'b0, q, -1, 0, 1'b0, sent, sn);
    compared++;
    if (sent[4:0] !== 5'b01000 || sn != 5) begin
      mismatched++; $display("FAIL gen5_bits got=%b n=%0d exp=01000 n=5", sent[4:0], sn);
    end
  endtask

  task automatic test_crc5_check();
    bit q[$]; logic [15:0] sent; int sn;
    zeros(q, 11);
    q.push_back(0); q.push_back(1); q.push_back(0); q.push_back(0); q.push_back(0);
    run_field(1'b0, 1'b1, q, -1, 0, 1'b0, sent, sn);
    compared++;
    if (dut5.crc !== 5'b01100) begin mismatched++; $display("FAIL chk5_crc got=%b exp=01100", dut5.crc); end
    q[3] = ~q[3];
    run_field(1'b0, 1'b1, q, -1, 0, 1'b0, sent, sn);
  endtask

  task automatic test_crc16();
    bit q[$]; logic [15:0] sent; int sn;
    zeros(q, 16);
    run_field(1'b1, 1'b1, q, -1, 0, 1'b0, sent, sn);
    zeros(q, 1);
    run_field(1'b1, 1'b0, q, -1, 0, 1'b0, sent, sn);
    compared++;
    if (sent !== 16'h8004 || sn != 16) begin
      mismatched++; $display("FAIL gen16_bits got=%h n=%0d exp=8004 n=16", sent, sn);
    end
  endtask

  task automatic test_halt();
    bit q[$]; logic [15:0] sent; int sn;
    zeros(q, 11);
    run_field(1'b0, 1'b0, q, 2, 3, 1'b0, sent, sn);
    compared++;
    if (sent[4:0] !== 5'b01000 || sn != 5) begin
      mismatched++; $display("FAIL halt_bits got=%b n=%0d exp=01000 n=5", sent[4:0], sn);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit q[$]; logic [15:0] sent; int sn;
    sel16 = 1'b0; mode = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    rst_L = 1'b0;
    #1;
    compared += 2;
    if (busy5 !== 1'b0) begin mismatched++; $display("FAIL midrst_busy got=%b exp=0", busy5); end
    if (dut5.crc !== 5'b11111) begin mismatched++; $display("FAIL midrst_crc got=%b exp=11111", dut5.crc); end
    @(negedge clk);
    rst_L = 1'b1; in_s = 1'b0; beg = 1'b0;
    zeros(q, 11);
    run_field(1'b0, 1'b0, q, -1, 0, 1'b0, sent, sn);
    compared++;
    if (sent[4:0] !== 5'b01000) begin mismatched++; $display("FAIL midrst_bits got=%b exp=01000", sent[4:0]); end
  endtask

  task automatic test_abort_restart();
    bit q[$]; logic [15:0] sent; int sn;
    sel16 = 1'b0; mode = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    zeros(q, 11);
    run_field(1'b0, 1'b0, q, -1, 0, 1'b1, sent, sn);
    compared++;
    if (sent[4:0] !== 5'b01000) begin mismatched++; $display("FAIL abort_bits got=%b exp=01000", sent[4:0]); end
  endtask

  task automatic test_idle_done();
    sel16 = 1'b0;
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    compared += 2;
    if (busy5 !== 1'b0) begin mismatched++; $display("FAIL idle_done_busy got=%b exp=0", busy5); end
    if (done5 !== 1'b0) begin mismatched++; $display("FAIL idle_done_pulse got=%b exp=0", done5); end
  endtask

  initial begin
    rst_L = 1'b0; in_s = 1'b0; beg = 1'b0; dn = 1'b0; mode = 1'b0; halt = 1'b0; sel16 = 1'b0;
    test_reset();
    test_crc5_gen();
    test_crc5_check();
    test_crc16();
    test_halt();
    test_reset_mid_shift();
    test_abort_restart();
    test_idle_done();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
